// File: rtl/mem_pkg.sv
// Shared types and helpers for the CPU memory subsystem.
// Holds the FSM state, operation and region encodings.
package mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_BAD
  } op_e;

  typedef enum logic [1:0] {
    RG_ROM,
    RG_RAM,
    RG_UNMAP
  } region_e;

  function automatic region_e decode(
    input logic [31:0] a,
    input int          rom_d,
    input int          ram_b,
    input int          ram_d
  );
    if (a < 32'(rom_d)) return RG_ROM;
    if (a >= 32'(ram_b) && a < 32'(ram_b + ram_d))
      return RG_RAM;
    return RG_UNMAP;
  endfunction

endpackage

// File: rtl/mem_subsystem_if.sv
// CPU bus and ROM loader signals of the memory subsystem.
// master = CPU/bench side, slave = memory subsystem.
interface mem_subsystem_if #(
  parameter int DATA_W = mem_pkg::DEF_DATA_W,
  parameter int ADDR_W = mem_pkg::DEF_ADDR_W
);

  logic [ADDR_W-1:0] addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_oe;
  logic              ready;
  logic              bus_err;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  modport master (
    output addr, mem_read, mem_write, wdata,
    output ld_valid, ld_addr, ld_data,
    input  rdata, rdata_oe, ready, bus_err,
    input  ld_ready
  );

  modport slave (
    input  addr, mem_read, mem_write, wdata,
    input  ld_valid, ld_addr, ld_data,
    output rdata, rdata_oe, ready, bus_err,
    output ld_ready
  );

endinterface

// File: rtl/mem_subsystem_sp_ram.sv
// Single-port RAM: synchronous write, registered read.
// Contents are not reset.
module sp_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_subsystem.sv
// ROM/RAM memory subsystem for the 8-bit CPU bus with
// wait-state insertion, error flagging and a ROM loader.
module mem_subsystem
  import mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int ROM_DEPTH = 256,
  parameter int RAM_BASE  = 'h0100,
  parameter int RAM_DEPTH = 4096,
  parameter int WAIT_RD   = 0,
  parameter int WAIT_WR   = 0
) (
  input  logic           clk,
  input  logic           reset,
  mem_subsystem_if.slave bus
);

  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam logic [3:0] CNT_RD = 4'(WAIT_RD);
  localparam logic [3:0] CNT_WR = 4'(WAIT_WR);

  state_e state_q, state_d;
  op_e    op_q, op_d, req_op, acc_op;
  region_e rgn_q, rgn_d, req_rgn, acc_rgn;

  logic [ADDR_W-1:0] addr_q, addr_d, acc_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, acc_wdata;
  logic [3:0]        cnt_q, cnt_d, req_cnt;

  logic req, fire, idle, done, err;
  logic ld_acc;
  logic rom_we, rom_re, ram_we, ram_re;
  logic [ROM_AW-1:0] rom_idx;
  logic [RAM_AW-1:0] ram_idx;
  logic [DATA_W-1:0] rom_dout, ram_dout;

  assign req  = bus.mem_read | bus.mem_write;
  assign idle = (state_q == ST_IDLE);
  assign done = (state_q == ST_DONE);

  always_comb begin
    req_op = OP_RD;
    unique case (1'b1)
      bus.mem_read & bus.mem_write:
        req_op = OP_BAD;
      bus.mem_write & ~bus.mem_read:
        req_op = OP_WR;
      default:
        req_op = OP_RD;
    endcase
    req_cnt = (req_op == OP_WR) ? CNT_WR : CNT_RD;
    req_rgn = decode(32'(bus.addr), ROM_DEPTH,
                     RAM_BASE, RAM_DEPTH);
  end

  // A request sampled in IDLE with zero wait states is
  // performed at once, so its access uses the live bus.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rgn_d   = rgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_d    = req_op;
          rgn_d   = req_rgn;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (req_cnt == 4'd0) begin
            state_d = ST_DONE;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = req_cnt - 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_op    = idle ? req_op    : op_q;
    acc_rgn   = idle ? req_rgn   : rgn_q;
    acc_addr  = idle ? bus.addr  : addr_q;
    acc_wdata = idle ? bus.wdata : wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_RD;
      rgn_q   <= RG_ROM;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rgn_q   <= rgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // CPU wins ties; the loader only owns the ROM port
  // in an idle cycle with no CPU request.
  assign ld_acc = bus.ld_valid & idle & ~req & ~reset;

  assign rom_we = ld_acc &
    (32'(bus.ld_addr) < 32'(ROM_DEPTH));
  assign rom_re = fire & ~reset &
    (acc_op == OP_RD) & (acc_rgn == RG_ROM);
  assign ram_we = fire & ~reset &
    (acc_op == OP_WR) & (acc_rgn == RG_RAM);
  assign ram_re = fire & ~reset &
    (acc_op == OP_RD) & (acc_rgn == RG_RAM);

  assign rom_idx = ld_acc ? ROM_AW'(bus.ld_addr)
                          : ROM_AW'(acc_addr);
  assign ram_idx =
    RAM_AW'(acc_addr - ADDR_W'(RAM_BASE));

  sp_ram #(
    .DEPTH (ROM_DEPTH),
    .WIDTH (DATA_W)
  ) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .re    (rom_re),
    .addr  (rom_idx),
    .wdata (bus.ld_data),
    .rdata (rom_dout)
  );

  sp_ram #(
    .DEPTH (RAM_DEPTH),
    .WIDTH (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_idx),
    .wdata (acc_wdata),
    .rdata (ram_dout)
  );

  assign err = (op_q == OP_BAD) |
               (rgn_q == RG_UNMAP) |
               ((op_q == OP_WR) & (rgn_q == RG_ROM));

  always_comb begin
    bus.rdata = '0;
    if (done) begin
      bus.rdata = '1;
      if (op_q == OP_RD && rgn_q == RG_ROM)
        bus.rdata = rom_dout;
      else if (op_q == OP_RD && rgn_q == RG_RAM)
        bus.rdata = ram_dout;
    end
  end

  assign bus.ready    = done;
  assign bus.bus_err  = done & err;
  assign bus.rdata_oe = done & (op_q == OP_RD);
  assign bus.ld_ready = ld_acc;

endmodule
